matrix_stream_loader: RTL and testbench

- Writer-side counterpart to the matrix/array display helpers: accepts a serial element stream over a valid/ready handshake and fills an internal ROWS x COLS integer matrix in row-major order (row outer, column inner).
- Provides a registered random-access read port so testbenches and downstream logic can inspect the loaded matrix.
- Sits between a stimulus or DMA source and any consumer that needs a complete 2D data set.

---
 rtl/matrix_stream_loader_if.sv | 11 +
 rtl/matrix_stream_loader.sv | 116 +++++++++++
 tb/tb_matrix_stream_loader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_stream_loader_if.sv
// Element stream handshake (valid/ready/data) between a source and the matrix loader.
interface matrix_stream_loader_if #(
    parameter int DATA_W = 32
) ();
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/matrix_stream_loader.sv
// Fills a ROWS x COLS matrix row-major from a valid/ready stream and exposes a
// registered random-access read port with read-before-write semantics.
module matrix_stream_loader #(
    parameter int ROWS   = 2,
    parameter int COLS   = 3,
    parameter int DATA_W = 32,
    parameter int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int CW     = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_clear,
    matrix_stream_loader_if.slave s_in,
    output logic [RW-1:0]        o_wr_row,
    output logic [CW-1:0]        o_wr_col,
    output logic                 o_busy,
    output logic                 o_full,
    output logic                 o_done,
    input  logic [RW-1:0]        i_rd_row,
    input  logic [CW-1:0]        i_rd_col,
    output logic [DATA_W-1:0]    o_rd_data
);

    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FULL
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [RW-1:0]       r_wr_row;
    logic [CW-1:0]       r_wr_col;
    logic                r_done;
    logic [DATA_W-1:0]   r_rd_data;
    logic [DATA_W-1:0]   r_mem [ROWS][COLS];

    logic                w_accept;
    logic                w_last_col;
    logic                w_last;
    logic                w_restart;
    logic                w_rd_ok;

    // clear outranks acceptance, so a beat in the clear cycle is never written
    assign w_accept   = s_in.valid && (r_state == S_LOAD) && !i_clear;
    assign w_last_col = (r_wr_col == LAST_COL);
    assign w_last     = w_accept && w_last_col && (r_wr_row == LAST_ROW);
    assign w_restart  = i_start && (r_state != S_LOAD);
    assign w_rd_ok    = (i_rd_row <= LAST_ROW) && (i_rd_col <= LAST_COL);

    // NOTE: next state gets a default before the case so no latch is inferred.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (i_start) w_next = S_LOAD;
            S_LOAD:  if (w_last)  w_next = S_FULL;
            S_FULL:  if (i_start) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
        if (i_clear) w_next = S_IDLE;
    end

    // NOTE: state and datapath registers use non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_row <= '0;
            r_wr_col <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last;
            if (i_clear || w_restart) begin
                r_wr_row <= '0;
                r_wr_col <= '0;
            end else if (w_accept) begin
                if (w_last_col) begin
                    r_wr_col <= '0;
                    r_wr_row <= (r_wr_row == LAST_ROW) ? '0 : r_wr_row + 1'b1;
                end else begin
                    r_wr_col <= r_wr_col + 1'b1;
                end
            end
        end
    end

    // NOTE: the matrix is reset because a reset must leave every element reading 0;
    // this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    r_mem[r][c] <= '0;
        end else begin
            r_rd_data <= w_rd_ok ? r_mem[i_rd_row][i_rd_col] : '0;
            if (w_accept) r_mem[r_wr_row][r_wr_col] <= s_in.data;
        end
    end

    assign s_in.ready = (r_state == S_LOAD);
    assign o_busy     = (r_state == S_LOAD);
    assign o_full     = (r_state == S_FULL);
    assign o_done     = r_done;
    assign o_wr_row   = r_wr_row;
    assign o_wr_col   = r_wr_col;
    assign o_rd_data  = r_rd_data;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader: a 2x3 instance driven from a vector
// table plus hand sequences, and a 1x1 instance for the degenerate case.
module tb_matrix_stream_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // 2x3 instance
    matrix_stream_loader_if #(.DATA_W(32)) s_if ();
    logic        start = 1'b0, clear = 1'b0;
    logic [0:0]  wr_row, rd_row = '0;
    logic [1:0]  wr_col, rd_col = '0;
    logic        busy, full, done;
    logic [31:0] rd_data;

    matrix_stream_loader #(.ROWS(2), .COLS(3), .DATA_W(32)) u_dut (
        .clk(clk), .rst(rst), .i_start(start), .i_clear(clear), .s_in(s_if.slave),
        .o_wr_row(wr_row), .o_wr_col(wr_col), .o_busy(busy), .o_full(full),
        .o_done(done), .i_rd_row(rd_row), .i_rd_col(rd_col), .o_rd_data(rd_data)
    );

    // 1x1 instance
    matrix_stream_loader_if #(.DATA_W(32)) s_if1 ();
    logic        start1 = 1'b0, clear1 = 1'b0;
    logic [0:0]  wr_row1, wr_col1, rd_row1 = '0, rd_col1 = '0;
    logic        busy1, full1, done1;
    logic [31:0] rd_data1;

    matrix_stream_loader #(.ROWS(1), .COLS(1), .DATA_W(32)) u_dut1 (
        .clk(clk), .rst(rst), .i_start(start1), .i_clear(clear1), .s_in(s_if1.slave),
        .o_wr_row(wr_row1), .o_wr_col(wr_col1), .o_busy(busy1), .o_full(full1),
        .o_done(done1), .i_rd_row(rd_row1), .i_rd_col(rd_col1), .o_rd_data(rd_data1)
    );

    typedef struct {
        logic        start, clear, valid;
        logic [31:0] data;
        logic [0:0]  rd_row;
        logic [1:0]  rd_col;
        logic        e_ready, e_busy, e_full, e_done;
        logic [0:0]  e_row;
        logic [1:0]  e_col;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input logic st, cl, v, input logic [31:0] d,
                                input logic [0:0] rr, input logic [1:0] rc,
                                input logic er, eb, ef, ed,
                                input logic [0:0] ew, input logic [1:0] ec,
                                input logic [31:0] erd);
        vec_t t;
        t.start = st; t.clear = cl; t.valid = v; t.data = d;
        t.rd_row = rr; t.rd_col = rc;
        t.e_ready = er; t.e_busy = eb; t.e_full = ef; t.e_done = ed;
        t.e_row = ew; t.e_col = ec; t.e_rd = erd;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic st, cl, v, input logic [31:0] d);
        @(negedge clk);
        start = st; clear = cl; s_if.valid = v; s_if.data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_rd(input string name, input int r, input int c, input logic [31:0] exp);
        @(negedge clk);
        start = 1'b0; clear = 1'b0; s_if.valid = 1'b0;
        rd_row = 1'(r); rd_col = 2'(c);
        @(posedge clk);
        #1;
        check(name, rd_data, exp);
    endtask

    task automatic check_status(input string tag, input logic er, eb, ef, ed,
                                input int row, input int col);
        check({tag, ".ready"}, 32'(s_if.ready), 32'(er));
        check({tag, ".busy"},  32'(busy),       32'(eb));
        check({tag, ".full"},  32'(full),       32'(ef));
        check({tag, ".done"},  32'(done),       32'(ed));
        check({tag, ".row"},   32'(wr_row),     32'(row));
        check({tag, ".col"},   32'(wr_col),     32'(col));
    endtask

    initial begin
        int k;
        logic v;

        s_if.valid = 1'b0;  s_if.data = '0;
        s_if1.valid = 1'b0; s_if1.data = '0;

        vecs[0] = mk(1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[1] = mk(0, 0, 1, 10, 0, 0, 1, 1, 0, 0, 0, 1, 0);   // read-before-write at [0][0]
        vecs[2] = mk(0, 0, 1, 11, 0, 0, 1, 1, 0, 0, 0, 2, 10);
        vecs[3] = mk(0, 0, 1, 12, 0, 0, 1, 1, 0, 0, 1, 0, 10);
        vecs[4] = mk(0, 0, 1, 13, 0, 0, 1, 1, 0, 0, 1, 1, 10);
        vecs[5] = mk(0, 0, 1, 14, 0, 0, 1, 1, 0, 0, 1, 2, 10);
        vecs[6] = mk(0, 0, 1, 15, 0, 0, 0, 0, 1, 1, 0, 0, 10);
        vecs[7] = mk(0, 0, 0, 0,  1, 2, 0, 0, 1, 0, 0, 0, 15);
        vecs[8] = mk(0, 0, 0, 0,  0, 1, 0, 0, 1, 0, 0, 0, 11);
        vecs[9] = mk(0, 0, 0, 0,  0, 3, 0, 0, 1, 0, 0, 0, 0);   // column out of range

        // Reset state, checked while reset is still asserted
        #2;
        check_status("reset", 0, 0, 0, 0, 0, 0);
        check("reset.rd_data", rd_data, 0);
        check("reset.done1", 32'(done1), 0);
        @(negedge clk);
        rst = 1'b0;

        // A beat offered in IDLE is dropped
        step(0, 0, 1, 77);
        check_status("idle_drop", 0, 0, 0, 0, 0, 0);
        check_rd("idle_drop.mem00", 0, 0, 0);

        // Default 2x3 load from the vector table
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = vecs[i].start; clear = vecs[i].clear;
            s_if.valid = vecs[i].valid; s_if.data = vecs[i].data;
            rd_row = vecs[i].rd_row; rd_col = vecs[i].rd_col;
            @(posedge clk);
            #1;
            check_status($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_busy,
                         vecs[i].e_full, vecs[i].e_done, 32'(vecs[i].e_row), 32'(vecs[i].e_col));
            check($sformatf("vec%0d.rd", i), rd_data, vecs[i].e_rd);
        end

        // Gapped stream: indices move only on valid cycles
        step(1, 0, 0, 0);
        k = 0;
        for (int i = 0; i < 12; i++) begin
            v = (i % 2 == 0);
            step(0, 0, v, v ? 32'(10 + k) : 32'hDEAD_BEEF);
            if (v) k++;
            check_status($sformatf("gap%0d", i), k < 6, k < 6, k == 6, v && (k == 6),
                         (k % 6) / 3, k % 3);
        end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                check_rd($sformatf("gap.mem%0d%0d", r, c), r, c, 32'(10 + 3 * r + c));

        // Reload with a start in the middle of the load
        step(1, 0, 0, 0);
        step(0, 0, 1, 100);
        step(0, 0, 1, 101);
        step(1, 0, 0, 0);
        check_status("mid_start", 1, 1, 0, 0, 0, 2);
        for (int i = 2; i < 6; i++) step(0, 0, 1, 32'(100 + i));
        check_status("reload_end", 0, 0, 1, 1, 0, 0);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                check_rd($sformatf("reload.mem%0d%0d", r, c), r, c, 32'(100 + 3 * r + c));

        // Clear after four beats, with a beat offered in the clear cycle
        step(1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(0, 0, 1, 32'(i));
        check_status("pre_clear", 1, 1, 0, 0, 1, 1);
        step(0, 1, 1, 5);
        check_status("clear", 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("clear.no_done", 32'(done), 0);
        check_rd("clear.mem00", 0, 0, 1);
        check_rd("clear.mem01", 0, 1, 2);
        check_rd("clear.mem02", 0, 2, 3);
        check_rd("clear.mem10", 1, 0, 4);
        check_rd("clear.mem11", 1, 1, 104);
        check_rd("clear.mem12", 1, 2, 105);

        // Reset in the middle of a load clears everything at once
        step(1, 0, 0, 0);
        step(0, 0, 1, 7);
        step(0, 0, 1, 8);
        @(negedge clk);
        start = 1'b0; s_if.valid = 1'b0;
        rst = 1'b1;
        #1;
        check_status("mid_rst", 0, 0, 0, 0, 0, 0);
        check("mid_rst.rd_data", rd_data, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                check_rd($sformatf("mid_rst.mem%0d%0d", r, c), r, c, 0);

        // Degenerate 1x1 matrix completes on the first beat
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        check("m1.busy", 32'(busy1), 1);
        check("m1.ready", 32'(s_if1.ready), 1);
        @(negedge clk);
        start1 = 1'b0; s_if1.valid = 1'b1; s_if1.data = 42;
        @(posedge clk);
        #1;
        check("m1.done", 32'(done1), 1);
        check("m1.full", 32'(full1), 1);
        check("m1.ready_after", 32'(s_if1.ready), 0);
        check("m1.row", 32'(wr_row1), 0);
        check("m1.col", 32'(wr_col1), 0);
        @(negedge clk);
        s_if1.valid = 1'b0;
        @(posedge clk);
        #1;
        check("m1.done_once", 32'(done1), 0);
        check("m1.mem00", rd_data1, 42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
